// File: rtl/cdp1802_dma_responder_pkg.sv
// cdp1802_pkg: state-code constants, responder state enum and the shared DMA/INT arbiter
package cdp1802_pkg;
  localparam logic [1:0] SC_FETCH = 2'b00;
  localparam logic [1:0] SC_EXEC  = 2'b01;
  localparam logic [1:0] SC_DMA   = 2'b10;
  localparam logic [1:0] SC_INT   = 2'b11;
  typedef enum logic [2:0] {IDLE, DOUT_REQ, DOUT_WAIT, DOUT_PRES, DIN_REQ, DIN_WAIT, DIN_PRES, INT} state_t;
  function automatic state_t arbitrate(input logic din_n, input logic dout_n, input logic int_req, input logic ie);
    return !din_n ? DIN_REQ : !dout_n ? DOUT_REQ : (int_req && ie) ? INT : IDLE;
  endfunction
endpackage

// File: rtl/cdp1802_dma_responder_if.sv
// cdp1802_dma_responder_if: core sequencer, video and memory signals of the DMA/INT responder
interface cdp1802_dma_responder_if #(parameter int ADDR_W = 16);
  logic clk_enable, boundary, ie, int_req, dma_out_n, dma_in_n, r0_wr;
  logic hold, int_ack, dma_strobe, mem_req, mem_we, mem_ack;
  logic [7:0] dma_in_data, dma_data, mem_wdata, mem_rdata;
  logic [ADDR_W-1:0] r0_wdata, r0, mem_addr;
  logic [1:0] SC;
  modport master (
    input  clk_enable, boundary, ie, int_req, dma_out_n, dma_in_n, dma_in_data, r0_wr, r0_wdata, mem_ack, mem_rdata,
    output r0, SC, hold, int_ack, dma_data, dma_strobe, mem_addr, mem_req, mem_we, mem_wdata
  );
  modport slave (
    output clk_enable, boundary, ie, int_req, dma_out_n, dma_in_n, dma_in_data, r0_wr, r0_wdata, mem_ack, mem_rdata,
    input  r0, SC, hold, int_ack, dma_data, dma_strobe, mem_addr, mem_req, mem_we, mem_wdata
  );
endinterface

// File: rtl/cdp1802_dma_responder.sv
// cdp1802_dma_responder: steals DMA/INT machine cycles, owns R0; DMA_IN_EN enables the DMA-in write path
module cdp1802_dma_responder
  import cdp1802_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter logic [ADDR_W-1:0] R0_RESET = '0
) (
  input logic clk,
  input logic reset,
  cdp1802_dma_responder_if.master b
);
  state_t r_state, w_arb;
  logic [1:0] r_sc;
  logic r_int_ack, r_mem_req;
  logic [ADDR_W-1:0] r_r0, r_mem_addr;
  logic [7:0] r_dma_data;
  logic w_din_n, w_pres, w_go, w_dma, w_din_cyc;
`ifdef DMA_IN_EN
  logic r_mem_we;
  logic [7:0] r_mem_wdata;
  assign w_din_n = b.dma_in_n;
  assign b.mem_we = r_mem_we;
  assign b.mem_wdata = r_mem_wdata;
`else
  assign w_din_n = 1'b1;
  assign b.mem_we = 1'b0;
  assign b.mem_wdata = 8'h00;
`endif
  assign w_arb = arbitrate(w_din_n, b.dma_out_n, b.int_req, b.ie);
  assign w_dma = w_arb inside {DOUT_REQ, DIN_REQ};
  assign w_pres = r_state inside {DOUT_PRES, DIN_PRES};
  assign w_din_cyc = r_state inside {DIN_REQ, DIN_WAIT};
  // a pending R0 write wins over a boundary sample in the same machine cycle
  assign w_go = b.clk_enable && (w_pres || (r_state == IDLE && b.boundary && !b.r0_wr));
  assign b.r0 = r_r0;
  assign b.SC = r_sc;
  assign b.hold = r_state != IDLE;
  assign b.int_ack = r_int_ack;
  assign b.dma_data = r_dma_data;
  assign b.dma_strobe = b.clk_enable && r_state == DOUT_PRES;
  assign b.mem_addr = r_mem_addr;
  assign b.mem_req = r_mem_req;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r_state <= IDLE;
      r_sc <= SC_FETCH;
      r_int_ack <= 1'b0;
      r_mem_req <= 1'b0;
      r_mem_addr <= '0;
      r_r0 <= R0_RESET;
      r_dma_data <= 8'h00;
`ifdef DMA_IN_EN
      r_mem_we <= 1'b0;
      r_mem_wdata <= 8'h00;
`endif
    end else begin
      r_int_ack <= 1'b0;
      if (w_go) begin
        r_state <= w_arb;
        r_sc <= w_arb == INT ? SC_INT : (w_dma && w_pres) ? SC_DMA : SC_FETCH;
        r_int_ack <= w_arb == INT;
        r_mem_req <= w_dma;
        r_mem_addr <= r_r0;
`ifdef DMA_IN_EN
        r_mem_we <= w_arb == DIN_REQ;
        r_mem_wdata <= b.dma_in_data;
`endif
      end else if (r_state == IDLE) begin
        if (b.clk_enable && b.r0_wr) r_r0 <= b.r0_wdata;
      end else if (r_state == INT) begin
        if (b.clk_enable) begin
          r_state <= IDLE;
          r_sc <= SC_FETCH;
        end
      end else if (!w_pres) begin
        // memory handshake runs at full clock rate, independent of clk_enable
        if (b.mem_ack) begin
          r_state <= w_din_cyc ? DIN_PRES : DOUT_PRES;
          r_sc <= SC_DMA;
          r_mem_req <= 1'b0;
          r_r0 <= r_r0 + ADDR_W'(1);
          if (!w_din_cyc) r_dma_data <= b.mem_rdata;
`ifdef DMA_IN_EN
          r_mem_we <= 1'b0;
`endif
        end else r_state <= r_state == DOUT_REQ ? DOUT_WAIT : r_state == DIN_REQ ? DIN_WAIT : r_state;
      end
    end
endmodule
